// File: rtl/game_undo_stack.sv
// game_undo_stack: live game state plus a circular history of up to DEPTH earlier states.
// Redo support is compiled in only when GAME_UNDO_REDO_EN is defined.
module game_undo_stack #(
  parameter int W     = 134,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  load_state,
  input  logic          push,
  input  logic [W-1:0]  push_state,
  input  logic          undo,
  input  logic          redo,
  output logic [W-1:0]  game_state,
  output logic [CW-1:0] undo_cnt,
  output logic [CW-1:0] redo_cnt,
  output logic          ack,
  output logic          nack
);
  localparam int PW = $clog2(DEPTH);
`ifdef GAME_UNDO_REDO_EN
  localparam bit REDO_EN = 1'b1;
`else
  localparam bit REDO_EN = 1'b0;
`endif
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  cur_reg, cur_next;
  logic [W-1:0]  hist_reg [DEPTH];
  logic [PW-1:0] wp_reg, wp_next, wp_prev;
  logic [CW-1:0] undo_cnt_reg, undo_cnt_next;
  logic [CW-1:0] redo_cnt_reg, redo_cnt_next;
  logic          ack_reg, ack_next, nack_reg, nack_next;
  logic          do_load, do_push, do_undo, do_redo;
  logic          push_ok, undo_ok, redo_ok;
  logic          wr_en;
  logic [PW-1:0] wr_addr;

  always_comb begin
    // Fixed priority: load > push > undo > redo; losers are silently dropped.
    do_load = en & load;
    do_push = en & ~load & push;
    do_undo = en & ~load & ~push & undo;
    do_redo = en & ~load & ~push & ~undo & redo & REDO_EN;
    push_ok = do_push && (push_state != cur_reg);
    undo_ok = do_undo && (undo_cnt_reg != '0);
    redo_ok = do_redo && (redo_cnt_reg != '0);
    wp_prev = wp_reg - PW'(1);

    cur_next      = cur_reg;
    wp_next       = wp_reg;
    undo_cnt_next = undo_cnt_reg;
    redo_cnt_next = redo_cnt_reg;
    wr_en         = 1'b0;
    wr_addr       = wp_reg;

    if (do_load) begin
      cur_next      = load_state;
      wp_next       = '0;
      undo_cnt_next = '0;
      redo_cnt_next = '0;
    end else if (push_ok) begin
      // A full history overwrites its oldest slot, which is the one at wp.
      wr_en         = 1'b1;
      wr_addr       = wp_reg;
      cur_next      = push_state;
      wp_next       = wp_reg + PW'(1);
      undo_cnt_next = (undo_cnt_reg == FULL) ? FULL : undo_cnt_reg + CW'(1);
      redo_cnt_next = '0;
    end else if (undo_ok) begin
      // Without redo the displaced live state is never read back, so skip the write.
      wr_en         = REDO_EN;
      wr_addr       = wp_prev;
      cur_next      = hist_reg[wp_prev];
      wp_next       = wp_prev;
      undo_cnt_next = undo_cnt_reg - CW'(1);
      redo_cnt_next = REDO_EN ? redo_cnt_reg + CW'(1) : '0;
    end else if (redo_ok) begin
      wr_en         = 1'b1;
      wr_addr       = wp_reg;
      cur_next      = hist_reg[wp_reg];
      wp_next       = wp_reg + PW'(1);
      undo_cnt_next = undo_cnt_reg + CW'(1);
      redo_cnt_next = redo_cnt_reg - CW'(1);
    end

    ack_next  = do_load | push_ok | undo_ok | redo_ok;
    nack_next = (do_push & ~push_ok) | (do_undo & ~undo_ok) | (do_redo & ~redo_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg      <= '0;
      wp_reg       <= '0;
      undo_cnt_reg <= '0;
      redo_cnt_reg <= '0;
      ack_reg      <= 1'b0;
      nack_reg     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_reg[i] <= '0;
    end else begin
      cur_reg      <= cur_next;
      wp_reg       <= wp_next;
      undo_cnt_reg <= undo_cnt_next;
      redo_cnt_reg <= redo_cnt_next;
      ack_reg      <= ack_next;
      nack_reg     <= nack_next;
      if (wr_en) hist_reg[wr_addr] <= cur_reg;
    end
  end

  assign game_state = cur_reg;
  assign undo_cnt   = undo_cnt_reg;
  assign redo_cnt   = redo_cnt_reg;
  assign ack        = ack_reg;
  assign nack       = nack_reg;
endmodule

// File: tb/tb_game_undo_stack.sv
// Scoreboard bench for game_undo_stack: queue-based undo/redo model, directed cases then random ops.
module tb_game_undo_stack;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef GAME_UNDO_REDO_EN
  localparam bit REDO_ON = 1'b1;
`else
  localparam bit REDO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, load = 1'b0, push = 1'b0, undo = 1'b0, redo = 1'b0;
  logic [W-1:0]  load_state = '0, push_state = '0;
  logic [W-1:0]  game_state;
  logic [CW-1:0] undo_cnt, redo_cnt;
  logic          ack, nack;

  always #5 clk = ~clk;

  game_undo_stack #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_state(load_state),
    .push(push), .push_state(push_state), .undo(undo), .redo(redo),
    .game_state(game_state), .undo_cnt(undo_cnt), .redo_cnt(redo_cnt),
    .ack(ack), .nack(nack)
  );

  typedef struct packed {
    logic [W-1:0]  gs;
    logic [CW-1:0] uc;
    logic [CW-1:0] rc;
    logic          ack;
    logic          nack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int checks = 0, errors = 0, txn = 0;

  // Reference model: live state plus two stacks of earlier / later states.
  logic [W-1:0] m_cur = '0;
  logic [W-1:0] m_undo[$];
  logic [W-1:0] m_redo[$];

  task automatic model_step(input bit e, input bit l, input logic [W-1:0] ls, input bit p,
                            input logic [W-1:0] ps, input bit u, input bit r,
                            output bit a, output bit n);
    a = 1'b0;
    n = 1'b0;
    if (e) begin
      if (l) begin
        m_cur = ls;
        m_undo.delete();
        m_redo.delete();
        a = 1'b1;
      end else if (p) begin
        if (ps == m_cur) n = 1'b1;
        else begin
          m_undo.push_back(m_cur);
          if (m_undo.size() > DEPTH) void'(m_undo.pop_front());
          m_redo.delete();
          m_cur = ps;
          a = 1'b1;
        end
      end else if (u) begin
        if (m_undo.size() == 0) n = 1'b1;
        else begin
          if (REDO_ON) m_redo.push_back(m_cur);
          m_cur = m_undo.pop_back();
          a = 1'b1;
        end
      end else if (r && REDO_ON) begin
        if (m_redo.size() == 0) n = 1'b1;
        else begin
          m_undo.push_back(m_cur);
          m_cur = m_redo.pop_back();
          a = 1'b1;
        end
      end
    end
  endtask

  function automatic exp_t snapshot(input bit a, input bit n);
    exp_t e;
    e.gs   = m_cur;
    e.uc   = CW'(m_undo.size());
    e.rc   = CW'(m_redo.size());
    e.ack  = a;
    e.nack = n;
    return e;
  endfunction

  task automatic op(input bit e, input bit l, input logic [W-1:0] ls, input bit p,
                    input logic [W-1:0] ps, input bit u, input bit r);
    bit a, n;
    exp_t x;
    @(negedge clk);
    en = e; load = l; load_state = ls; push = p; push_state = ps; undo = u; redo = r;
    model_step(e, l, ls, p, ps, u, r, a, n);
    x = snapshot(a, n);
    @(posedge clk);
    #1;
    en = 1'b0; load = 1'b0; push = 1'b0; undo = 1'b0; redo = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic do_load(input logic [W-1:0] v); op(1, 1, v, 0, '0, 0, 0); endtask
  task automatic do_push(input logic [W-1:0] v); op(1, 0, '0, 1, v, 0, 0); endtask
  task automatic do_undo(); op(1, 0, '0, 0, '0, 1, 0); endtask
  task automatic do_redo(); op(1, 0, '0, 0, '0, 0, 1); endtask

  // Asserts reset mid-cycle so the monitor sees the cleared outputs before any edge.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_cur = '0;
    m_undo.delete();
    m_redo.delete();
    exp_q.push_back(snapshot(0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn %0d: got 0x%0h expected 0x%0h", name, txn, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      txn++;
      $display("txn %0d: state=%02h undo=%0d redo=%0d ack=%0b nack=%0b rst_n=%0b",
               txn, game_state, undo_cnt, redo_cnt, ack, nack, rst_n);
      chk("game_state", 32'(game_state), 32'(mx.gs));
      chk("undo_cnt",   32'(undo_cnt),   32'(mx.uc));
      chk("redo_cnt",   32'(redo_cnt),   32'(mx.rc));
      chk("ack",        32'(ack),        32'(mx.ack));
      chk("nack",       32'(nack),       32'(mx.nack));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit e, l, p, u, r;
    logic [W-1:0] v;
    int sel;

    exp_q.push_back(snapshot(0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic push/undo/redo chain.
    do_load(8'h11);
    do_push(8'h22); do_push(8'h33); do_push(8'h44);
    repeat (4) do_undo();
    do_redo(); do_redo();
    do_push(8'h55);
    do_redo();

    // History overflow: oldest states fall off.
    do_load(8'h01);
    for (int i = 2; i <= 7; i++) do_push(W'(i));
    repeat (5) do_undo();

    // Priority, no-op push, disabled cycle.
    op(1, 1, 8'hA0, 1, 8'hB0, 1, 1);
    do_push(8'hA0);
    do_push(8'hB1);
    op(0, 0, '0, 0, '0, 1, 0);
    op(1, 0, '0, 0, '0, 1, 1);

    // Reset in the middle of an undo sequence.
    do_load(8'h10);
    do_push(8'h20); do_push(8'h30); do_push(8'h40);
    do_undo();
    apply_reset();
    do_undo();
    do_redo();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) == 0) apply_reset();
      sel = int'($urandom_range(15));
      e = ($urandom_range(15) != 0);
      l = (sel == 0);
      p = (sel >= 1 && sel <= 6);
      u = (sel >= 7 && sel <= 10);
      r = (sel >= 11);
      if ($urandom_range(7) == 0) begin
        p = p | ($urandom_range(1) == 1);
        u = u | ($urandom_range(1) == 1);
        r = r | ($urandom_range(1) == 1);
      end
      v = ($urandom_range(3) == 0) ? m_cur : W'($urandom);
      op(e, l, W'($urandom), p, v, u, r);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_undo_stack.md
# game_undo_stack

Parametrised N-level undo/redo history for the game state vector, the successor to the fixed three-deep retract chain. Holds the live game state plus a circular history of up to DEPTH earlier states, so moves can be undone and re-applied. Sits between move generation (box/man move results, level init) and the renderer/win checker, which consume `game_state`.

## Interface
- `W`, 134, game state vector width
- `DEPTH`, 8, history slots; power of two, ≥2
- `CW`, $clog2(DEPTH+1), width of count outputs
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  global enable; when low, no op is accepted and all state holds
- `load`  in  1  load `load_state` as live state; clears all history
- `load_state`  in  W  level-init state
- `push`  in  1  commit `push_state` as a new move
- `push_state`  in  W  post-move state (box or man move result)
- `undo`  in  1  step back one state
- `redo`  in  1  step forward one state (see Configuration)
- `game_state`  out  W  live state, registered
- `undo_cnt`  out  CW  states available to undo, 0..DEPTH
- `redo_cnt`  out  CW  states available to redo, 0..DEPTH
- `ack`  out  1  one-cycle pulse: previous-cycle op accepted
- `nack`  out  1  one-cycle pulse: previous-cycle op rejected

## Operation
- Storage: `cur` register (drives `game_state`), `hist[0..DEPTH-1]`, write pointer `wp` (log2 DEPTH bits, wraps modulo DEPTH), `undo_cnt`, `redo_cnt`.
- Op selected only when `en`=1; fixed priority load > push > undo > redo; lower-priority requests in the same cycle are dropped (no ack/nack for them).
- load: `cur`←`load_state`; `wp`←0; both counts←0; ack.
- push: if `push_state`==`cur`, no-op move: nothing changes, nack. Else `hist[wp]`←`cur`, `cur`←`push_state`, `wp`←`wp`+1, `undo_cnt`←min(`undo_cnt`+1, DEPTH), `redo_cnt`←0, ack. When `undo_cnt`=DEPTH the oldest entry is overwritten silently.
- undo: if `undo_cnt`=0, nack, no change. Else swap: `cur`←`hist[wp-1]`, `hist[wp-1]`←`cur`, `wp`←`wp`-1, `undo_cnt`−1, `redo_cnt`+1, ack.
- redo: if `redo_cnt`=0, nack, no change. Else swap: `cur`←`hist[wp]`, `hist[wp]`←`cur`, `wp`←`wp`+1, `undo_cnt`+1, `redo_cnt`−1, ack.
- Invariant: `undo_cnt`+`redo_cnt` ≤ DEPTH at all times.
- No request with `en`=1: ack=nack=0, state holds.

## Timing
- Single-cycle ops; `game_state`, counts, ack/nack all update on the edge sampling the request; visible the following cycle.
- Back-to-back ops every cycle are legal; each sees the result of the previous.
- Reset (async assert, any time, including mid-sequence): `cur`=0, all `hist`=0, `wp`=0, `undo_cnt`=0, `redo_cnt`=0, ack=0, nack=0. Release synchronous to `clk` by the system reset synchroniser.
- `en`=0 cycle: requests ignored, ack=nack=0.
- Pointer wrap: `wp`=DEPTH-1 +1 → 0; `wp`=0 −1 → DEPTH-1.

## Configuration
- `GAME_UNDO_REDO_EN` defined: redo as above.
- Not defined: `redo` input ignored (no ack/nack), `redo_cnt` tied to 0, undo does not need to write back to `hist` (swap reduced to read); undo/push/load behaviour otherwise identical.

## Test plan
- W=8, DEPTH=4, redo enabled: reset → `game_state`=0x00, counts 0, ack=nack=0; load 0x11 → `game_state`=0x11, ack one cycle.
- Push 0x22, 0x33, 0x44 → `undo_cnt`=3; undo ×3 → `game_state` 0x33, 0x22, 0x11, `redo_cnt`=3; 4th undo → nack, state 0x11.
- From 0x11 with `redo_cnt`=3: redo ×2 → 0x22, 0x33; push 0x55 → `redo_cnt`=0, `undo_cnt`=3; redo → nack.
- Overflow: load 0x01, push 0x02..0x07 (6 pushes) → `undo_cnt`=4; undo ×4 → 0x06, 0x05, 0x04, 0x03; 5th undo nack.
- Simultaneous load+push+undo → load wins, single ack, counts 0; push of value equal to `game_state` → nack, counts unchanged; `en`=0 with undo → no change, no pulse.
- Assert `rst_n` low mid-undo-sequence with `undo_cnt`=2 → all outputs 0 immediately; undo after release → nack. Repeat key cases with `GAME_UNDO_REDO_EN` undefined: redo ignored, `redo_cnt`=0.
